// File: rtl/seg7_scan_capture_if.sv
// Display-bus bundle for the 7-segment scan capture block.
// master: the side driving the scanned display bus and capture request.
// slave : the capture block, which returns the captured result and status.
interface seg7_scan_capture_if;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic        capture;
    logic [15:0] value;
    logic        valid;
    logic        busy;
    logic        err;
    logic [3:0]  err_digit;
    logic        timeout;

    modport master (
        output seg_in, dig_sel, capture,
        input  value, valid, busy, err, err_digit, timeout
    );

    modport slave (
        input  seg_in, dig_sel, capture,
        output value, valid, busy, err, err_digit, timeout
    );
endinterface

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed, active-low 7-segment hex display and reconstructs
// the four displayed hex digits into a 16-bit value. Each digit is accepted
// once it has been seen unchanged for STABLE_CYC consecutive one-hot samples;
// the scan aborts after TIMEOUT_CYC cycles if not all digits were seen.
module seg7_scan_capture #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                resetn,
    seg7_scan_capture_if.slave  bus
);

    localparam int             TCW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TCW-1:0] LAST = TCW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]     STAB = 4'(STABLE_CYC);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state_q;
    logic [10:0]     prev_q;
    logic [3:0]      stab_q, stab_d;
    logic [TCW-1:0]  tcnt_q;
    logic [3:0]      mask_q, mask_d;
    logic [3:0]      errd_q, errd_d;
    logic [15:0]     shadow_q, shadow_d;
    logic [15:0]     value_q;
    logic            valid_q, err_q, timeout_q;
    logic [3:0]      err_digit_q;
    logic            onehot, accept;
    logic [4:0]      dec;

    // Reverse map of a segment pattern: {legal, nibble}; illegal gives 5'h00.
    function automatic logic [4:0] hex_decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: return 5'h10;
            7'b1111001: return 5'h11;
            7'b0100100: return 5'h12;
            7'b0110000: return 5'h13;
            7'b0011001: return 5'h14;
            7'b0010010: return 5'h15;
            7'b0000010: return 5'h16;
            7'b1111000: return 5'h17;
            7'b0000000: return 5'h18;
            7'b0010000: return 5'h19;
            7'b0001000: return 5'h1A;
            7'b0000011: return 5'h1B;
            7'b1000110: return 5'h1C;
            7'b0100001: return 5'h1D;
            7'b0000110: return 5'h1E;
            7'b0001110: return 5'h1F;
            default:    return 5'h00;
        endcase
    endfunction

    // Sample qualification, stability counting and digit acceptance.
    always_comb begin
        onehot   = (bus.dig_sel != 4'd0) &&
                   ((bus.dig_sel & (bus.dig_sel - 4'd1)) == 4'd0);
        dec      = hex_decode(bus.seg_in);
        stab_d   = 4'd0;
        if (onehot) begin
            if ({bus.dig_sel, bus.seg_in} == prev_q)
                stab_d = (stab_q == 4'hF) ? 4'hF : stab_q + 4'd1;
            else
                stab_d = 4'd1;
        end
        // An already-captured digit is never re-sampled within a capture.
        accept   = onehot && (stab_d == STAB) && ((mask_q & bus.dig_sel) == 4'd0);
        mask_d   = mask_q | (accept ? bus.dig_sel : 4'd0);
        errd_d   = errd_q | ((accept && !dec[4]) ? bus.dig_sel : 4'd0);
        shadow_d = shadow_q;
        for (int i = 0; i < 4; i++) begin
            if (accept && bus.dig_sel[i])
                shadow_d[4*i +: 4] = dec[3:0];
        end
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            stab_q      <= '0;
            tcnt_q      <= '0;
            mask_q      <= '0;
            errd_q      <= '0;
            shadow_q    <= '0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            err_digit_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            prev_q <= {bus.dig_sel, bus.seg_in};
            case (state_q)
                IDLE, DONE: begin
                    if (bus.capture) begin
                        state_q     <= SCAN;
                        stab_q      <= '0;
                        tcnt_q      <= '0;
                        mask_q      <= '0;
                        errd_q      <= '0;
                        valid_q     <= 1'b0;
                        err_q       <= 1'b0;
                        err_digit_q <= '0;
                        timeout_q   <= 1'b0;
                    end
                end
                SCAN: begin
                    if (mask_q == 4'hF) begin
                        // Completion wins over a timeout landing on the same cycle.
                        state_q     <= DONE;
                        value_q     <= shadow_q;
                        err_digit_q <= errd_q;
                        err_q       <= |errd_q;
                        valid_q     <= (errd_q == 4'd0);
                    end else begin
                        stab_q   <= stab_d;
                        mask_q   <= mask_d;
                        errd_q   <= errd_d;
                        shadow_q <= shadow_d;
                        if (tcnt_q == LAST) begin
                            // A final digit landing on the last budget cycle
                            // still completes on the following cycle.
                            if (mask_d != 4'hF) begin
                                state_q   <= DONE;
                                timeout_q <= 1'b1;
                            end
                        end else begin
                            tcnt_q <= tcnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.value     = value_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = (state_q == SCAN);
    assign bus.err       = err_q;
    assign bus.err_digit = err_digit_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: normal capture, unstable digit,
// illegal digit, timeout, non-one-hot select with mid-scan reset, and
// capture requests arriving during a scan.
module tb_seg7_scan_capture;

    logic clk;
    logic resetn;
    int   total;
    int   bad;

    seg7_scan_capture_if bus ();

    seg7_scan_capture #(.STABLE_CYC(4), .TIMEOUT_CYC(1024)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] d, input logic [6:0] s, input int n);
        bus.dig_sel = d;
        bus.seg_in  = s;
        repeat (n) tick();
    endtask

    task automatic pulse_cap();
        bus.capture = 1'b1;
        tick();
        bus.capture = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] v, input logic vl,
                           input logic bs, input logic er, input logic [3:0] ed,
                           input logic to);
        chk({tag, ".value"},     32'(bus.value),     32'(v));
        chk({tag, ".valid"},     32'(bus.valid),     32'(vl));
        chk({tag, ".busy"},      32'(bus.busy),      32'(bs));
        chk({tag, ".err"},       32'(bus.err),       32'(er));
        chk({tag, ".err_digit"}, 32'(bus.err_digit), 32'(ed));
        chk({tag, ".timeout"},   32'(bus.timeout),   32'(to));
    endtask

    initial begin
        logic [3:0] rot;
        total       = 0;
        bad         = 0;
        resetn      = 1'b0;
        bus.capture = 1'b0;
        bus.dig_sel = 4'b0000;
        bus.seg_in  = 7'b1111111;
        repeat (2) tick();
        chk_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        resetn = 1'b1;
        tick();
        chk("idle.busy", 32'(bus.busy), 32'd0);

        // Normal capture F,7,A,3 with capture requests during the scan.
        pulse_cap();
        chk_all("cap1.start", 16'h0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        present(4'b0001, 7'b0001110, 4);
        present(4'b0010, 7'b1111000, 4);
        bus.capture = 1'b1;
        present(4'b0100, 7'b0001000, 4);
        bus.capture = 1'b0;
        present(4'b1000, 7'b0110000, 3);
        bus.capture = 1'b1;
        present(4'b1000, 7'b0110000, 1);
        chk("cap1.busy_after_accept", 32'(bus.busy), 32'd1);
        tick();
        bus.capture = 1'b0;
        chk_all("cap1.done", 16'h3A7F, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        tick();
        chk_all("cap1.hold", 16'h3A7F, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);

        // Restart from DONE; unstable digit 1, gapped digit 2, no overwrite of digit 0.
        pulse_cap();
        chk_all("cap2.start", 16'h3A7F, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        present(4'b0001, 7'b1000000, 4);
        present(4'b0010, 7'b1111001, 3);
        present(4'b0010, 7'b0100100, 4);
        present(4'b0100, 7'b0011001, 3);
        present(4'b0000, 7'b0011001, 1);
        present(4'b0100, 7'b0011001, 3);
        present(4'b0001, 7'b0000010, 5);
        present(4'b1000, 7'b0010010, 5);
        chk("cap2.digit2_missing", 32'(bus.busy), 32'd1);
        present(4'b0100, 7'b0011001, 4);
        chk("cap2.busy_after_accept", 32'(bus.busy), 32'd1);
        tick();
        chk_all("cap2.done", 16'h5420, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);

        // Illegal dash pattern on digit 2.
        pulse_cap();
        present(4'b0001, 7'b0000000, 4);
        present(4'b0010, 7'b0010000, 4);
        present(4'b0100, 7'b0111111, 4);
        present(4'b1000, 7'b0000011, 4);
        tick();
        chk_all("cap3.done", 16'hB098, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0);

        // Timeout: digit 3 never presented.
        pulse_cap();
        rot = 4'b0001;
        for (int i = 0; i < 1023; i++) begin
            if (i % 4 == 0)
                rot = (rot == 4'b0100) ? 4'b0001 : (rot << 1);
            bus.dig_sel = rot;
            bus.seg_in  = 7'b1000000;
            tick();
        end
        chk("tmo.still_busy", 32'(bus.busy), 32'd1);
        tick();
        chk_all("tmo.done", 16'hB098, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);

        // Non-one-hot select, then reset in the middle of the scan.
        pulse_cap();
        present(4'b0011, 7'b1000000, 10);
        present(4'b0010, 7'b1111001, 4);
        present(4'b0100, 7'b0100100, 4);
        present(4'b1000, 7'b0110000, 4);
        tick();
        chk("oh.no_digit0", 32'(bus.busy), 32'd1);
        resetn = 1'b0;
        #2;
        chk_all("oh.async_reset", 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        resetn = 1'b1;
        pulse_cap();
        chk("post_reset.busy", 32'(bus.busy), 32'd1);
        present(4'b0001, 7'b1111001, 4);
        present(4'b0010, 7'b0100100, 4);
        present(4'b0100, 7'b0110000, 4);
        present(4'b1000, 7'b0011001, 4);
        tick();
        chk_all("post_reset.done", 16'h4321, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
